// File: rtl/sim_host_pkg.sv
// sim_host_pkg: shared constants and types for the simulation host port.
//   Default bus addresses for the three store targets, the pass result code,
//   the exit code reported on a timeout, and the exit-source enumeration used
//   to select which status update (if any) happens on a given edge.
package sim_host_pkg;

   localparam logic [31:0] ADDR_PUTCHAR      = 32'h1000_0000;
   localparam logic [31:0] ADDR_RESULT       = 32'h1000_1000;
   localparam logic [31:0] ADDR_TOHOST       = 32'h0000_1000;
   localparam logic [7:0]  PASS_CODE         = 8'h03;
   localparam logic [31:0] TIMEOUT_EXIT_CODE = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      SRC_NONE,
      SRC_RESULT,
      SRC_TOHOST,
      SRC_TIMEOUT
   } exit_src_e;

endpackage

// File: rtl/sim_host_port_sync_fifo.sv
// sync_fifo: single-clock FIFO with wrapping read/write pointers.
//   clk, rstn   : clock, asynchronous active-low reset (empties the FIFO)
//   push        : write request; accepted when not full, or when full and a
//                 pop is accepted in the same cycle
//   push_data   : data written on an accepted push
//   full, empty : occupancy flags
//   pop         : read request; accepted when not empty
//   pop_data    : head entry (valid while !empty), no fall-through
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   output logic             full,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign empty    = (count == '0);
   assign full     = (count == (AW+1)'(DEPTH));
   assign do_pop   = pop & ~empty;
   assign do_push  = push & (~full | do_pop);
   assign pop_data = mem[rd_ptr];

   // Storage carries no reset; emptiness is tracked by count alone.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         // DEPTH is a power of two, so pointer overflow wraps naturally.
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/sim_host_port.sv
// sim_host_port: write-only memory-mapped host device for guest programs.
//   clk, rstn    : clock, asynchronous active-low reset
//   bus_*        : store snoop (valid, write, wmask, wdata, addr); never stalls
//   char_valid/char_data/char_ready : buffered putchar byte stream
//   done/pass/fail/timeout : sticky run status
//   exit_code    : captured exit value
//   dropped      : putchar bytes lost to a full FIFO (saturating)
//   cycles       : cycles since reset release, frozen at done (saturating)
module sim_host_port
   import sim_host_pkg::*;
#(
   parameter logic [31:0] ADDR_PUTCHAR   = sim_host_pkg::ADDR_PUTCHAR,
   parameter logic [31:0] ADDR_RESULT    = sim_host_pkg::ADDR_RESULT,
   parameter logic [31:0] ADDR_TOHOST    = sim_host_pkg::ADDR_TOHOST,
   parameter logic [7:0]  PASS_CODE      = sim_host_pkg::PASS_CODE,
   parameter int unsigned FIFO_DEPTH     = 16,
   parameter int unsigned TIMEOUT_CYCLES = 20000
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        bus_valid,
   input  logic        bus_write,
   input  logic [3:0]  bus_wmask,
   input  logic [31:0] bus_wdata,
   input  logic [31:0] bus_addr,
   output logic        char_valid,
   output logic [7:0]  char_data,
   input  logic        char_ready,
   output logic        done,
   output logic        pass,
   output logic        fail,
   output logic        timeout,
   output logic [31:0] exit_code,
   output logic [15:0] dropped,
   output logic [31:0] cycles
);

   localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

   logic      store;
   logic      hit_putchar;
   logic      hit_result;
   logic      hit_tohost;
   logic      fifo_full;
   logic      fifo_empty;
   logic      pop;
   logic [7:0] fifo_head;
   logic      timeout_hit;
   exit_src_e src;

   assign store       = bus_valid & bus_write & bus_wmask[0];
   assign hit_putchar = store & (bus_addr == ADDR_PUTCHAR);
   assign hit_result  = store & (bus_addr == ADDR_RESULT);
   assign hit_tohost  = store & (bus_addr == ADDR_TOHOST);

   assign char_valid = ~fifo_empty;
   assign pop        = char_valid & char_ready;
   // Gate the head entry so stale storage never shows after a reset.
   assign char_data  = fifo_empty ? '0 : fifo_head;

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rstn      (rstn),
      .push      (hit_putchar),
      .push_data (bus_wdata[7:0]),
      .full      (fifo_full),
      .pop       (pop),
      .pop_data  (fifo_head),
      .empty     (fifo_empty)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         dropped <= '0;
      end else if (hit_putchar && fifo_full && !pop && dropped != '1) begin
         dropped <= dropped + 1'b1;
      end
   end

   always_comb begin
      timeout_hit = 1'b0;
      if (TIMEOUT_CYCLES != 0) begin
         timeout_hit = (cycles == TIMEOUT_LAST);
      end
   end

   // Exit stores take priority over a coinciding timeout expiry.
   always_comb begin
      src = SRC_NONE;
      if (!done) begin
         if (hit_result)                      src = SRC_RESULT;
         else if (hit_tohost && bus_wdata[0]) src = SRC_TOHOST;
         else if (timeout_hit)                src = SRC_TIMEOUT;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         done      <= 1'b0;
         pass      <= 1'b0;
         fail      <= 1'b0;
         timeout   <= 1'b0;
         exit_code <= '0;
      end else begin
         case (src)
            SRC_RESULT: begin
               done      <= 1'b1;
               exit_code <= bus_wdata;
               pass      <= (bus_wdata[7:0] == PASS_CODE);
               fail      <= (bus_wdata[7:0] != PASS_CODE);
            end
            SRC_TOHOST: begin
               done      <= 1'b1;
               exit_code <= {1'b0, bus_wdata[31:1]};
               pass      <= (bus_wdata[31:1] == '0);
               fail      <= (bus_wdata[31:1] != '0);
            end
            SRC_TIMEOUT: begin
               done      <= 1'b1;
               timeout   <= 1'b1;
               fail      <= 1'b1;
               exit_code <= TIMEOUT_EXIT_CODE;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cycles <= '0;
      end else if (!done && cycles != '1) begin
         cycles <= cycles + 1'b1;
      end
   end

endmodule

// File: tb/tb_sim_host_port.sv
// tb_sim_host_port: directed, table-driven bench for sim_host_port with a
// 100-cycle timeout budget so the expiry corner is reachable quickly.
module tb_sim_host_port;
   import sim_host_pkg::*;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        bus_valid = 1'b0;
   logic        bus_write = 1'b0;
   logic [3:0]  bus_wmask = 4'h0;
   logic [31:0] bus_wdata = '0;
   logic [31:0] bus_addr = '0;
   logic        char_valid;
   logic [7:0]  char_data;
   logic        char_ready = 1'b0;
   logic        done;
   logic        pass;
   logic        fail;
   logic        timeout;
   logic [31:0] exit_code;
   logic [15:0] dropped;
   logic [31:0] cycles;

   int checks = 0;
   int errors = 0;

   sim_host_port #(
      .FIFO_DEPTH     (16),
      .TIMEOUT_CYCLES (100)
   ) dut (
      .clk        (clk),
      .rstn       (rstn),
      .bus_valid  (bus_valid),
      .bus_write  (bus_write),
      .bus_wmask  (bus_wmask),
      .bus_wdata  (bus_wdata),
      .bus_addr   (bus_addr),
      .char_valid (char_valid),
      .char_data  (char_data),
      .char_ready (char_ready),
      .done       (done),
      .pass       (pass),
      .fail       (fail),
      .timeout    (timeout),
      .exit_code  (exit_code),
      .dropped    (dropped),
      .cycles     (cycles)
   );

   always #5 clk = ~clk;

   typedef enum int {K_IDLE, K_PUT, K_RES, K_TOH} kind_e;

   typedef struct {
      kind_e       kind;
      logic [3:0]  wmask;
      logic [31:0] data;
      logic        rdy;
      logic        e_cv;
      logic [7:0]  e_cd;
      logic        e_done;
      logic        e_pass;
      logic        e_fail;
      logic [31:0] e_exit;
      logic [31:0] e_cycles;
   } vec_t;

   vec_t tbl[11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input kind_e k, input logic [3:0] m, input logic [31:0] d, input logic rdy);
      bus_valid  = (k != K_IDLE);
      bus_write  = 1'b1;
      bus_wmask  = m;
      bus_wdata  = d;
      char_ready = rdy;
      case (k)
         K_PUT:   bus_addr = ADDR_PUTCHAR;
         K_RES:   bus_addr = ADDR_RESULT;
         K_TOH:   bus_addr = ADDR_TOHOST;
         default: bus_addr = 32'h0;
      endcase
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Leaves rstn released 1 ns after an edge, so the next edge makes cycles=1.
   task automatic do_reset();
      rstn = 1'b0;
      drive(K_IDLE, 4'hF, 32'h0, 1'b0);
      step();
      step();
      rstn = 1'b1;
   endtask

   function automatic vec_t mk(kind_e k, logic [3:0] m, logic [31:0] d, logic r,
                               logic cv, logic [7:0] cd, logic dn, logic ps,
                               logic fl, logic [31:0] ex, logic [31:0] cy);
      vec_t v;
      v.kind = k;  v.wmask = m; v.data = d; v.rdy = r;
      v.e_cv = cv; v.e_cd = cd; v.e_done = dn; v.e_pass = ps;
      v.e_fail = fl; v.e_exit = ex; v.e_cycles = cy;
      return v;
   endfunction

   initial begin
      int n;

      // Expected values are the state just after the edge that applies the row.
      tbl[0]  = mk(K_PUT, 4'hF, 32'h48, 1'b1, 1'b1, 8'h48, 1'b0, 1'b0, 1'b0, 32'h0, 32'd1);
      tbl[1]  = mk(K_PUT, 4'hF, 32'h69, 1'b1, 1'b1, 8'h69, 1'b0, 1'b0, 1'b0, 32'h0, 32'd2);
      tbl[2]  = mk(K_PUT, 4'hF, 32'h0A, 1'b1, 1'b1, 8'h0A, 1'b0, 1'b0, 1'b0, 32'h0, 32'd3);
      tbl[3]  = mk(K_IDLE,4'hF, 32'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0, 32'd4);
      tbl[4]  = mk(K_RES, 4'hE, 32'h03, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0, 32'd5);
      tbl[5]  = mk(K_RES, 4'hF, 32'h03, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h3, 32'd6);
      tbl[6]  = mk(K_RES, 4'hF, 32'h05, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h3, 32'd6);
      tbl[7]  = mk(K_TOH, 4'hF, 32'h0B, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h3, 32'd6);
      tbl[8]  = mk(K_PUT, 4'hF, 32'h5A, 1'b0, 1'b1, 8'h5A, 1'b1, 1'b1, 1'b0, 32'h3, 32'd6);
      tbl[9]  = mk(K_IDLE,4'hF, 32'h00, 1'b0, 1'b1, 8'h5A, 1'b1, 1'b1, 1'b0, 32'h3, 32'd6);
      tbl[10] = mk(K_IDLE,4'hF, 32'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h3, 32'd6);

      // Reset state
      rstn = 1'b0;
      step();
      check("rst_char_valid", 32'(char_valid), 32'h0);
      check("rst_char_data",  32'(char_data),  32'h0);
      check("rst_done",       32'(done),       32'h0);
      check("rst_pass",       32'(pass),       32'h0);
      check("rst_fail",       32'(fail),       32'h0);
      check("rst_timeout",    32'(timeout),    32'h0);
      check("rst_exit_code",  exit_code,       32'h0);
      check("rst_dropped",    32'(dropped),    32'h0);
      check("rst_cycles",     cycles,          32'h0);

      // Table: "Hi\n" stream, masked store, result pass, ignored late exits
      do_reset();
      for (int i = 0; i < 11; i++) begin
         drive(tbl[i].kind, tbl[i].wmask, tbl[i].data, tbl[i].rdy);
         step();
         check($sformatf("v%0d_char_valid", i), 32'(char_valid), 32'(tbl[i].e_cv));
         check($sformatf("v%0d_char_data", i),  32'(char_data),  32'(tbl[i].e_cd));
         check($sformatf("v%0d_done", i),       32'(done),       32'(tbl[i].e_done));
         check($sformatf("v%0d_pass", i),       32'(pass),       32'(tbl[i].e_pass));
         check($sformatf("v%0d_fail", i),       32'(fail),       32'(tbl[i].e_fail));
         check($sformatf("v%0d_exit_code", i),  exit_code,       tbl[i].e_exit);
         check($sformatf("v%0d_cycles", i),     cycles,          tbl[i].e_cycles);
         check($sformatf("v%0d_dropped", i),    32'(dropped),    32'h0);
      end

      // FIFO overflow, then push+pop on a full FIFO, then drain order
      do_reset();
      for (int i = 0; i < 20; i++) begin
         drive(K_PUT, 4'hF, 32'h40 + 32'(i), 1'b0);
         step();
      end
      check("ovf_dropped", 32'(dropped),   32'd4);
      check("ovf_head",    32'(char_data), 32'h40);
      drive(K_PUT, 4'hF, 32'h99, 1'b1);
      step();
      check("full_pushpop_dropped", 32'(dropped),   32'd4);
      check("full_pushpop_head",    32'(char_data), 32'h41);
      drive(K_IDLE, 4'hF, 32'h0, 1'b1);
      for (int i = 0; i < 16; i++) begin
         check($sformatf("drain%0d_valid", i), 32'(char_valid), 32'h1);
         check($sformatf("drain%0d_data", i), 32'(char_data),
               (i < 15) ? 32'h41 + 32'(i) : 32'h99);
         step();
      end
      check("drain_empty", 32'(char_valid), 32'h0);

      // Tohost fail code, ignored even value, tohost pass
      do_reset();
      drive(K_TOH, 4'hF, 32'h0000_000B, 1'b0);
      step();
      check("toh_fail_done", 32'(done), 32'h1);
      check("toh_fail_exit", exit_code, 32'h5);
      check("toh_fail_fail", 32'(fail), 32'h1);
      check("toh_fail_pass", 32'(pass), 32'h0);
      do_reset();
      drive(K_TOH, 4'hF, 32'h0000_0002, 1'b0);
      step();
      check("toh_even_done", 32'(done), 32'h0);
      drive(K_TOH, 4'hF, 32'h0000_0001, 1'b0);
      step();
      check("toh_pass_done", 32'(done), 32'h1);
      check("toh_pass_pass", 32'(pass), 32'h1);
      check("toh_pass_fail", 32'(fail), 32'h0);
      check("toh_pass_exit", exit_code, 32'h0);

      // Timeout expiry with no stores (bounded wait)
      do_reset();
      n = 0;
      while (!done && n < 200) begin
         step();
         n++;
      end
      check("to_edges",   32'(n),       32'd100);
      check("to_done",    32'(done),    32'h1);
      check("to_timeout", 32'(timeout), 32'h1);
      check("to_fail",    32'(fail),    32'h1);
      check("to_pass",    32'(pass),    32'h0);
      check("to_exit",    exit_code,    32'hFFFF_FFFF);
      check("to_cycles",  cycles,       32'd100);
      step();
      step();
      check("to_cycles_frozen", cycles, 32'd100);

      // Result store in the expiry cycle wins over the timeout
      do_reset();
      for (int i = 0; i < 99; i++) step();
      check("race_pre_done", 32'(done), 32'h0);
      drive(K_RES, 4'hF, 32'h03, 1'b0);
      step();
      check("race_done",    32'(done),    32'h1);
      check("race_timeout", 32'(timeout), 32'h0);
      check("race_pass",    32'(pass),    32'h1);
      check("race_exit",    exit_code,    32'h3);
      check("race_cycles",  cycles,       32'd100);

      // Asynchronous reset mid-stream with bytes queued and done set
      do_reset();
      for (int i = 0; i < 5; i++) begin
         drive(K_PUT, 4'hF, 32'h30 + 32'(i), 1'b0);
         step();
      end
      drive(K_RES, 4'hF, 32'h07, 1'b0);
      step();
      drive(K_IDLE, 4'hF, 32'h0, 1'b0);
      check("mid_pre_done",  32'(done),       32'h1);
      check("mid_pre_fail",  32'(fail),       32'h1);
      check("mid_pre_valid", 32'(char_valid), 32'h1);
      #2;
      rstn = 1'b0;
      #1;
      check("mid_char_valid", 32'(char_valid), 32'h0);
      check("mid_char_data",  32'(char_data),  32'h0);
      check("mid_done",       32'(done),       32'h0);
      check("mid_fail",       32'(fail),       32'h0);
      check("mid_exit",       exit_code,       32'h0);
      check("mid_cycles",     cycles,          32'h0);
      step();
      rstn = 1'b1;
      step();
      check("post_cycles", cycles,          32'd1);
      check("post_valid",  32'(char_valid), 32'h0);
      check("post_done",   32'(done),       32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
